nco_sweep_ctrl: RTL and testbench

Sequences the sin/cos NCO through a stepped-frequency sweep for the frequency response analyzer. Per point it drives the NCO phase increment, waits a settle interval, then opens a measurement window of fixed length. It then hands the point to the downstream magnitude/phase measurement block over a done/ack handshake. Sits between the host configuration registers and the NCO `phi_inc_i` / `clken` inputs.

---
 rtl/nco_sweep_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for the FRA NCO: settle, dwell window, point handoff.
// Optional `NCO_SWEEP_CONTINUOUS_EN` makes the sweep repeat until abort.
module nco_sweep_ctrl #(
  parameter int APR     = 11,
  parameter int NPW     = 10,
  parameter int CW      = 16,
  parameter int NCO_LAT = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic [APR-1:0] cfg_f_start,
  input  logic [APR-1:0] cfg_f_step,
  input  logic [NPW-1:0] cfg_npts,
  input  logic [CW-1:0]  cfg_settle,
  input  logic [CW-1:0]  cfg_dwell,
  output logic [APR-1:0] phi_inc_o,
  output logic           nco_clken,
  output logic           meas_win,
  output logic           pt_done,
  input  logic           pt_ack,
  output logic [NPW-1:0] pt_idx,
  output logic           busy,
  output logic           sweep_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_DWELL, S_WAIT_ACK, S_NEXT, S_FINISH
  } state_t;

  localparam logic [CW:0] LAT = (CW+1)'(NCO_LAT);

  state_t         state_q, state_d;
  logic [CW:0]    cnt_q, cnt_d;
  logic [APR-1:0] f_step_q, f_step_d;
  logic [NPW-1:0] npts_q, npts_d;
  logic [CW-1:0]  settle_q, settle_d, dwell_q, dwell_d;
  logic [APR-1:0] phi_q, phi_d;
  logic [NPW-1:0] idx_q, idx_d;
  logic           clken_q, clken_d, win_q, win_d, done_q, done_d;
  logic           busy_q, busy_d, swdone_q, swdone_d;
`ifdef NCO_SWEEP_CONTINUOUS_EN
  logic [APR-1:0] f_start_q, f_start_d;
`endif

  // Counter is one bit wider than the config so NCO_LAT + cfg_settle cannot overflow.
  logic [CW:0] settle_tot, settle_last, dwell_last;
  assign settle_tot  = LAT + {1'b0, settle_q};
  assign settle_last = (settle_tot == '0) ? '0 : settle_tot - (CW+1)'(1);
  assign dwell_last  = (dwell_q == '0) ? '0 : {1'b0, dwell_q} - (CW+1)'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f_step_d = f_step_q;
    npts_d   = npts_q;
    settle_d = settle_q;
    dwell_d  = dwell_q;
    phi_d    = phi_q;
    idx_d    = idx_q;
    clken_d  = clken_q;
    win_d    = win_q;
    done_d   = done_q;
    busy_d   = busy_q;
    swdone_d = 1'b0;
`ifdef NCO_SWEEP_CONTINUOUS_EN
    f_start_d = f_start_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f_step_d = cfg_f_step;
          npts_d   = cfg_npts;
          settle_d = cfg_settle;
          dwell_d  = cfg_dwell;
`ifdef NCO_SWEEP_CONTINUOUS_EN
          f_start_d = cfg_f_start;
`endif
          if (cfg_npts != '0) begin
            state_d = S_SETTLE;
            phi_d   = cfg_f_start;
            idx_d   = '0;
            busy_d  = 1'b1;
            clken_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == settle_last) begin
          state_d = S_DWELL;
          cnt_d   = '0;
          win_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + (CW+1)'(1);
        end
      end
      S_DWELL: begin
        if (cnt_q == dwell_last) begin
          state_d = S_WAIT_ACK;
          cnt_d   = '0;
          win_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + (CW+1)'(1);
        end
      end
      S_WAIT_ACK: begin
        if (pt_ack) begin
          done_d  = 1'b0;
          state_d = (idx_q == npts_q - NPW'(1)) ? S_FINISH : S_NEXT;
        end
      end
      S_NEXT: begin
        phi_d   = phi_q + f_step_q;
        idx_d   = idx_q + NPW'(1);
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_FINISH: begin
        swdone_d = 1'b1;
`ifdef NCO_SWEEP_CONTINUOUS_EN
        if (npts_q != '0) begin
          phi_d   = f_start_q;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          busy_d  = 1'b0;
          clken_d = 1'b0;
          state_d = S_IDLE;
        end
`else
        busy_d  = 1'b0;
        clken_d = 1'b0;
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides ack and counter expiry; the point in flight is dropped silently.
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      busy_d   = 1'b0;
      clken_d  = 1'b0;
      win_d    = 1'b0;
      done_d   = 1'b0;
      swdone_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f_step_q <= '0;
      npts_q   <= '0;
      settle_q <= '0;
      dwell_q  <= '0;
      phi_q    <= '0;
      idx_q    <= '0;
      clken_q  <= 1'b0;
      win_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      swdone_q <= 1'b0;
`ifdef NCO_SWEEP_CONTINUOUS_EN
      f_start_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f_step_q <= f_step_d;
      npts_q   <= npts_d;
      settle_q <= settle_d;
      dwell_q  <= dwell_d;
      phi_q    <= phi_d;
      idx_q    <= idx_d;
      clken_q  <= clken_d;
      win_q    <= win_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      swdone_q <= swdone_d;
`ifdef NCO_SWEEP_CONTINUOUS_EN
      f_start_q <= f_start_d;
`endif
    end
  end

  assign phi_inc_o  = phi_q;
  assign nco_clken  = clken_q;
  assign meas_win   = win_q;
  assign pt_done    = done_q;
  assign pt_idx     = idx_q;
  assign busy       = busy_q;
  assign sweep_done = swdone_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: expected points are queued at launch and
// compared when pt_done rises; window length, settle latency and ack hold are measured.
module tb_nco_sweep_ctrl;

  logic        clk, reset, start, abort, pt_ack;
  logic [10:0] cfg_f_start, cfg_f_step, phi_inc_o;
  logic [9:0]  cfg_npts, pt_idx;
  logic [15:0] cfg_settle, cfg_dwell;
  logic        nco_clken, meas_win, pt_done, busy, sweep_done;

  nco_sweep_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_f_start(cfg_f_start), .cfg_f_step(cfg_f_step), .cfg_npts(cfg_npts),
    .cfg_settle(cfg_settle), .cfg_dwell(cfg_dwell),
    .phi_inc_o(phi_inc_o), .nco_clken(nco_clken), .meas_win(meas_win),
    .pt_done(pt_done), .pt_ack(pt_ack), .pt_idx(pt_idx),
    .busy(busy), .sweep_done(sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] phi;
    logic [9:0]  idx;
    int          lat;
    int          dwell;
    int          hold;
  } rec_t;

  rec_t exp_q[$];
  rec_t cur;
  bit   cur_v;
  int   total, bad;
  int   sd_cnt, cyc, ack_delay;
  bit   ack_force;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge.
  initial begin
    bit busy_p, done_p, win_p;
    int settle_start, lat_meas, win_cnt, hold;
    busy_p = 0; done_p = 0; win_p = 0;
    settle_start = 0; lat_meas = 0; win_cnt = 0; hold = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !busy_p) begin settle_start = cyc; win_cnt = 0; end
      if (!pt_done && done_p) begin
        settle_start = cyc + 1;
        if (cur_v) begin
          chk("ack_hold", hold, cur.hold);
          chk("phi_at_ack", phi_inc_o, cur.phi);
        end
        cur_v = 0;
      end
      if (meas_win && !win_p) lat_meas = cyc - settle_start;
      if (meas_win) win_cnt++;
      if (pt_done && !done_p) begin
        hold = 0;
        if (exp_q.size() == 0) chk("pt_unexp", 1, 0);
        else begin
          cur = exp_q.pop_front();
          cur_v = 1;
          chk("pt_phi", phi_inc_o, cur.phi);
          chk("pt_idx", pt_idx, cur.idx);
          chk("pt_lat", lat_meas, cur.lat);
          chk("pt_win", win_cnt, cur.dwell);
        end
        win_cnt = 0;
      end
      if (pt_done) hold++;
      if (sweep_done) sd_cnt++;
      busy_p = busy; done_p = pt_done; win_p = meas_win;
    end
  end

  // Ack responder: acks ack_delay samples after pt_done is first seen.
  initial begin
    int wc;
    bit sent, own;
    wc = -1; sent = 0;
    pt_ack = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      own = 0;
      if (pt_done && !sent) begin
        if (wc < 0) wc = ack_delay;
        if (wc == 0) begin own = 1; sent = 1; end
        else wc--;
      end
      if (!pt_done) begin sent = 0; wc = -1; end
      pt_ack = own | ack_force;
    end
  end

  task automatic push_pt(input int fs, input int step, input int i, input int idx,
                         input int settle, input int dwell, input int ad);
    rec_t r;
    r.phi   = 11'(fs + i * step);
    r.idx   = 10'(idx);
    r.lat   = 6 + settle;
    r.dwell = (dwell == 0) ? 1 : dwell;
    r.hold  = ad + 1;
    exp_q.push_back(r);
  endtask

  task automatic launch(input int fs, input int step, input int n,
                        input int settle, input int dwell, input int ad);
    ack_delay = ad;
    for (int i = 0; i < n; i++) push_pt(fs, step, i, i, settle, dwell, ad);
    cfg_f_start = 11'(fs); cfg_f_step = 11'(step); cfg_npts = 10'(n);
    cfg_settle = 16'(settle); cfg_dwell = 16'(dwell);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble config: the running sweep must use its captured copy.
    cfg_f_start = 11'h5a5; cfg_f_step = 11'h3; cfg_npts = 10'd1;
    cfg_settle = 16'd40; cfg_dwell = 16'd9;
  endtask

  task automatic wait_sweep(input int sd0);
    for (int i = 0; i < 5000 && sd_cnt == sd0; i++) tick();
    chk("sd_seen", sd_cnt - sd0, 1);
    chk("busy_end", busy, 0);
    chk("clken_end", nco_clken, 0);
    tick(); tick();
    chk("sd_once", sd_cnt - sd0, 1);
    chk("q_empty", exp_q.size(), 0);
  endtask

  initial begin
    int sd0;
    total = 0; bad = 0; sd_cnt = 0; cyc = 0; ack_delay = 0; ack_force = 0; cur_v = 0;
    reset = 1'b1; start = 0; abort = 0;
    cfg_f_start = 0; cfg_f_step = 0; cfg_npts = 0; cfg_settle = 0; cfg_dwell = 0;
    tick(); tick();
    chk("rst_phi", phi_inc_o, 0);
    chk("rst_outs", {nco_clken, meas_win, pt_done, busy, sweep_done}, 0);
    chk("rst_idx", pt_idx, 0);
    reset = 1'b0;
    tick();

`ifdef NCO_SWEEP_CONTINUOUS_EN
    sd0 = sd_cnt;
    for (int i = 0; i < 5; i++) push_pt(300, 40, i % 2, i % 2, 1, 2, 0);
    launch(300, 40, 2, 1, 2, 0);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
    chk("cont_drain", exp_q.size(), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("cont_busy", busy, 0);
    chk("cont_clken", nco_clken, 0);
    tick(); tick();
    chk("cont_sd", sd_cnt - sd0, 2);
`else
    // Basic sweep, with a stray start mid-sweep that must be ignored.
    sd0 = sd_cnt;
    launch(100, 50, 3, 2, 4, 1);
    chk("busy_run", busy, 1);
    chk("clken_run", nco_clken, 1);
    for (int i = 0; i < 2000 && pt_idx != 1; i++) tick();
    chk("reach_idx1", pt_idx, 1);
    cfg_npts = 10'd7; cfg_f_start = 11'd5;
    start = 1'b1; tick(); start = 1'b0;
    chk("idx_after_start", pt_idx, 1);
    wait_sweep(sd0);

    // Phase-increment wrap, dwell=0 treated as 1.
    sd0 = sd_cnt;
    launch(2000, 100, 2, 0, 0, 0);
    wait_sweep(sd0);

    // Ack stall.
    sd0 = sd_cnt;
    launch(300, 7, 2, 3, 2, 20);
    wait_sweep(sd0);

    // Abort during DWELL of point 1 with ack in the same cycle.
    sd0 = sd_cnt;
    launch(400, 10, 3, 1, 6, 0);
    for (int i = 0; i < 2000 && !(pt_idx == 1 && meas_win); i++) tick();
    chk("reach_dwell1", {pt_idx, meas_win}, {10'd1, 1'b1});
    tick();
    abort = 1'b1; ack_force = 1'b1;
    tick();
    abort = 1'b0; ack_force = 1'b0;
    chk("abort_outs", {busy, meas_win, pt_done, nco_clken}, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_sd", sd_cnt - sd0, 0);
    chk("abort_left", exp_q.size(), 2);
    exp_q.delete();

    // npts = 0: sweep_done two cycles after start, no window.
    sd0 = sd_cnt;
    cfg_npts = 10'd0; cfg_f_start = 11'd9; cfg_f_step = 11'd1;
    cfg_settle = 16'd0; cfg_dwell = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("np0_sd_c1", sweep_done, 0);
    tick();
    chk("np0_sd_c2", sweep_done, 1);
    chk("np0_win", meas_win, 0);
    tick();
    chk("np0_sd_c3", sweep_done, 0);
    chk("np0_sd_cnt", sd_cnt - sd0, 1);

    // Async reset mid-SETTLE, then a clean sweep.
    launch(700, 3, 3, 0, 2, 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("arst_phi", phi_inc_o, 0);
    chk("arst_outs", {nco_clken, meas_win, pt_done, busy, sweep_done}, 0);
    chk("arst_idx", pt_idx, 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    sd0 = sd_cnt;
    launch(10, 1, 4, 0, 3, 2);
    wait_sweep(sd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
